timer_arbiter: RTL
==================

# timer_arbiter

Two-requester bus arbiter in front of the shared general timer peripheral, so both subsystems can program and read one timer instance. It serialises the two memory-mapped request ports onto the timer's single slave port using round-robin arbitration. It routes the timer's one-cycle-delayed read data back to the requester that issued the read. It tracks which requester currently owns the timer and steers the timer interrupt only to that owner.

## Interface
- No parameters; register offsets and requester indices live in the shared package.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rN_cs_i  in  1  requester N (N = 0, 1) selects timer
- rN_read_i / rN_write_i  in  1  read / write strobe
- rN_address_i  in  32  byte address
- rN_mode_i  in  2  privilege mode, forwarded
- rN_size_i  in  2  access size, forwarded
- rN_data_i  in  32  write data
- rN_stall_o  out  1  hold request; not accepted this cycle
- rN_abort_v_o  out  3  abort vector, granted requester only
- rN_data_o  out  32  read data, valid the cycle after an accepted read
- rN_ireq_o  out  1  timer interrupt, asserted only for the owner
- t_cs_o, t_read_o, t_write_o  out  1  to timer
- t_address_o  out  32  to timer
- t_mode_o, t_size_o  out  2  to timer
- t_data_o  out  32  to timer
- t_stall_i  in  1  from timer
- t_abort_v_i  in  3  from timer
- t_data_i  in  32  from timer; registered read data
- t_ireq_i  in  1  from timer

## Operation
- Single-cycle transactions. A request is accepted in a cycle when it is granted and t_stall_i = 0.
- Grant rules:
  - Only one rN_cs_i high: that requester is granted.
  - Both high: the requester indicated by the priority pointer `prio` is granted.
  - The loser sees rN_stall_o = 1 and must hold all its request signals stable.
- `prio` update: after an accepted contested grant to requester X, `prio` becomes 1-X. `prio` is unchanged when there is no contest or when the grant is stalled.
- Grant lock:
  - While t_stall_i = 1, the current grant is frozen, even if the other requester asserts cs.
  - The granted requester also sees rN_stall_o = 1.
  - A register `locked` with `lock_id` holds the frozen grant until t_stall_i falls.
- Forwarding:
  - The granted requester's signals are muxed onto the t_* outputs.
  - No grant: t_cs_o = t_read_o = t_write_o = 0; address and data are 0.
- Read return:
  - On an accepted read, register `rd_pend` = 1 and `rd_tag` = granted index.
  - Next cycle, rN_data_o = t_data_i for N = rd_tag. All other cases drive 32'h0.
- Abort: t_abort_v_i is passed only to the granted requester; the other requester gets 3'h0.
- Ownership:
  - An accepted write whose address[4:2] is CTRL (3), CLR (4) or SET (5) sets `owner` = writer index on the next edge.
  - rN_ireq_o = t_ireq_i && (owner == N).
  - Writes to COUNT or LIMIT do not change `owner`.

## Timing
- Reset values: prio = 0, owner = 0, rd_pend = 0, rd_tag = 0, locked = 0.
- After reset: all rN_data_o = 0, rN_ireq_o follows t_ireq_i for requester 0 only, and stalls and aborts are combinational from the inputs.
- Request path is combinational, zero added latency: t_cs_o follows rN_cs_i in the same cycle.
- Read data latency is exactly one cycle after acceptance, matching the timer's registered data_out.
- Back-to-back reads from alternating requesters return data on consecutive cycles, each tagged correctly.
- Simultaneous events:
  - Contest plus t_stall_i: the winner is decided by `prio`, then frozen by the lock. `prio` does not update until acceptance.
  - A read returning in the same cycle as a new accepted read from the other requester: the data goes to the old rd_tag, and rd_tag updates at the edge.
- Reset mid-transaction: a pending read return is discarded (rN_data_o = 0 next cycle) and the lock is cleared.
- A requester dropping cs while stalled is a protocol violation; the arbiter re-arbitrates the next cycle.

## Structure
- Shared package `timer_pkg` holds:
  - Register index constants: TMR_COUNT = 3'h0, TMR_LIMIT = 3'h1, TMR_CTRL = 3'h3, TMR_CLR = 3'h4, TMR_SET = 3'h5.
  - Requester indices: REQ0 = 1'b0, REQ1 = 1'b1.
  - Abort-vector width.
- One natural sub-module: `rr_arb2`, the two-way round-robin grant with pointer and lock.
- Muxing, read tagging and ownership stay in timer_arbiter.

## Test plan
- Reset, then r0 reads LIMIT (addr 0x04) with timer t_data_i = 0x0000_1234 next cycle -> r0_data_o = 0x0000_1234 one cycle later; r1_data_o = 0.
- Both cs high with prio = 0, two cycles -> cycle 1 grants r0 with r1_stall_o = 1; cycle 2 grants r1; prio ends at 0.
- r1 writes CTRL (0x0C, data 0x5) -> owner = 1. Timer then raises t_ireq_i -> r1_ireq_o = 1 and r0_ireq_o = 0. An r0 write to COUNT keeps owner = 1.
- r0 granted with t_stall_i = 1 for 3 cycles while r1 asserts cs -> r0 stays on the t_* bus and both stall. r0 is accepted on cycle 4, r1 is granted on cycle 5.
- Alternating reads r0 (COUNT), r1 (CTRL) on consecutive cycles -> returned data lands on r0 then r1 with no swap.
- Reset asserted the cycle after an accepted r1 read -> r1_data_o = 0 and owner = 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer arbiter slice.
// Register indices, requester ids and the request bundle.
package timer_pkg;

  localparam int ABORT_W = 3;

  localparam logic [2:0] TMR_COUNT = 3'h0;
  localparam logic [2:0] TMR_LIMIT = 3'h1;
  localparam logic [2:0] TMR_CTRL  = 3'h3;
  localparam logic [2:0] TMR_CLR   = 3'h4;
  localparam logic [2:0] TMR_SET   = 3'h5;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        cs;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [1:0]  mode;
    logic [1:0]  size;
    logic [31:0] data;
  } tmr_req_t;

  // Writes to these registers claim the timer interrupt.
  function automatic logic is_own_reg(input logic [2:0] idx);
    return (idx == TMR_CTRL) ||
           (idx == TMR_CLR)  ||
           (idx == TMR_SET);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a stall lock.
// A stalled grant stays frozen until the slave accepts it.
module rr_arb2
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic       gnt_vld,
  output logic       gnt_id,
  output logic       accept
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       lock_id_q;
  logic       prio_q;
  logic       lock_hit;
  logic       contest;

  // Grant selection: lock first, then pointer, then lone requester.
  always_comb begin
    lock_hit = (state_q == ARB_LOCK) && req[lock_id_q];
    contest  = &req;
    gnt_vld  = |req;
    gnt_id   = REQ0;
    unique case (1'b1)
      lock_hit:
        gnt_id = lock_id_q;
      !lock_hit && contest:
        gnt_id = prio_q;
      !lock_hit && (req == 2'b10):
        gnt_id = REQ1;
      default:
        gnt_id = REQ0;
    endcase
    accept  = gnt_vld && !hold;
    state_d = (gnt_vld && hold) ? ARB_LOCK
                                : ARB_OPEN;
  end

  // Lock state and frozen id follow the slave stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= REQ0;
    end else begin
      state_q <= state_d;
      if (gnt_vld && hold)
        lock_id_q <= gnt_id;
    end
  end

  // Pointer moves past the winner of an accepted contest only.
  always_ff @(posedge clk) begin
    if (reset)
      prio_q <= REQ0;
    else if (accept && contest)
      prio_q <= ~gnt_id;
  end

endmodule

// File: rtl/timer_arbiter.sv
// Two-requester front end for the shared general timer.
// Muxes requests, tags read returns and steers the irq.
module timer_arbiter
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,

  input  logic               r0_cs_i,
  input  logic               r0_read_i,
  input  logic               r0_write_i,
  input  logic [31:0]        r0_address_i,
  input  logic [1:0]         r0_mode_i,
  input  logic [1:0]         r0_size_i,
  input  logic [31:0]        r0_data_i,
  output logic               r0_stall_o,
  output logic [ABORT_W-1:0] r0_abort_v_o,
  output logic [31:0]        r0_data_o,
  output logic               r0_ireq_o,

  input  logic               r1_cs_i,
  input  logic               r1_read_i,
  input  logic               r1_write_i,
  input  logic [31:0]        r1_address_i,
  input  logic [1:0]         r1_mode_i,
  input  logic [1:0]         r1_size_i,
  input  logic [31:0]        r1_data_i,
  output logic               r1_stall_o,
  output logic [ABORT_W-1:0] r1_abort_v_o,
  output logic [31:0]        r1_data_o,
  output logic               r1_ireq_o,

  output logic               t_cs_o,
  output logic               t_read_o,
  output logic               t_write_o,
  output logic [31:0]        t_address_o,
  output logic [1:0]         t_mode_o,
  output logic [1:0]         t_size_o,
  output logic [31:0]        t_data_o,
  input  logic               t_stall_i,
  input  logic [ABORT_W-1:0] t_abort_v_i,
  input  logic [31:0]        t_data_i,
  input  logic               t_ireq_i
);

  tmr_req_t req [2];
  tmr_req_t fwd;
  logic     gnt_vld;
  logic     gnt_id;
  logic     accept;
  logic     g0;
  logic     g1;
  logic     rd_pend;
  logic     rd_tag;
  logic     owner;

  // Bundle each requester's port signals.
  always_comb begin
    req[0] = {r0_cs_i, r0_read_i, r0_write_i,
              r0_address_i, r0_mode_i,
              r0_size_i, r0_data_i};
    req[1] = {r1_cs_i, r1_read_i, r1_write_i,
              r1_address_i, r1_mode_i,
              r1_size_i, r1_data_i};
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({r1_cs_i, r0_cs_i}),
    .hold    (t_stall_i),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .accept  (accept)
  );

  // Forward the granted request, or an idle bus.
  always_comb begin
    fwd         = gnt_vld ? req[gnt_id] : '0;
    t_cs_o      = fwd.cs;
    t_read_o    = fwd.read;
    t_write_o   = fwd.write;
    t_address_o = fwd.address;
    t_mode_o    = fwd.mode;
    t_size_o    = fwd.size;
    t_data_o    = fwd.data;
  end

  // Stalls, aborts, read data and irq back to requesters.
  always_comb begin
    g0 = gnt_vld && (gnt_id == REQ0);
    g1 = gnt_vld && (gnt_id == REQ1);
    r0_stall_o   = r0_cs_i && (!g0 || t_stall_i);
    r1_stall_o   = r1_cs_i && (!g1 || t_stall_i);
    r0_abort_v_o = g0 ? t_abort_v_i : '0;
    r1_abort_v_o = g1 ? t_abort_v_i : '0;
    r0_data_o    = '0;
    r1_data_o    = '0;
    if (rd_pend && !reset) begin
      if (rd_tag == REQ0)
        r0_data_o = t_data_i;
      else
        r1_data_o = t_data_i;
    end
    r0_ireq_o = t_ireq_i && (owner == REQ0);
    r1_ireq_o = t_ireq_i && (owner == REQ1);
  end

  // Remember who issued the read so the return is steered.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag  <= REQ0;
    end else begin
      rd_pend <= accept && fwd.read;
      if (accept && fwd.read)
        rd_tag <= gnt_id;
    end
  end

  // Last writer of a control register owns the interrupt.
  always_ff @(posedge clk) begin
    if (reset)
      owner <= REQ0;
    else if (accept && fwd.write &&
             is_own_reg(fwd.address[4:2]))
      owner <= gnt_id;
  end

endmodule
